// File: rtl/ft_pkg.sv
// Shared types and default constants for the recovery controller.
package ft_pkg;

    localparam int unsigned DEF_WIDTH     = 32;
    localparam int unsigned DEF_MAX_RETRY = 3;
    localparam int unsigned DEF_TIMEOUT   = 64;
    localparam int unsigned ERR_W         = 16;

    typedef enum logic [2:0] {
        RUN       = 3'd0,
        HALT      = 3'd1,
        ROLLBACK  = 3'd2,
        WAIT_DONE = 3'd3,
        FAULT     = 3'd4
    } rec_state_t;

    // Bits needed to hold the value maxval without wrapping (at least 1).
    function automatic int unsigned cnt_width(input int unsigned maxval);
        return (maxval < 2) ? 1 : $clog2(maxval + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with increment enable that sticks at all-ones.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next value: hold by default, step only when enabled and not saturated.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1))
            count_d = count_q + W'(1);
    end

    // Count register, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/recovery_ctrl.sv
// Checkpoint / rollback controller for a lockstep core pair.
module recovery_ctrl
    import ft_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned MAX_RETRY = DEF_MAX_RETRY,
    parameter int unsigned TIMEOUT   = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             result_valid,
    input  logic             signal,
    input  logic [WIDTH-1:0] data,
    input  logic             rollback_done,
    output logic             halt,
    output logic             rollback,
    output logic [WIDTH-1:0] rollback_data,
    output logic             commit_valid,
    output logic [WIDTH-1:0] commit_data,
    output logic             fault,
    output logic [15:0]      error_count
);

    localparam int unsigned RW = cnt_width(MAX_RETRY);
    localparam int unsigned TW = cnt_width(TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

    rec_state_t       state_q;
    rec_state_t       state_d;
    logic [RW-1:0]    retry_q;
    logic [TW-1:0]    tcnt_q;
    logic [WIDTH-1:0] ckpt_q;
    logic             halt_q;
    logic             rollback_q;
    logic             commit_valid_q;
    logic             fault_q;
    logic             take_commit;
    logic             take_err;

    // Next-state decode; inputs are only looked at in the state that owns them.
    always_comb begin
        state_d     = state_q;
        take_commit = 1'b0;
        take_err    = 1'b0;
        case (state_q)
            RUN: begin
                if (result_valid) begin
                    if (signal) begin
                        take_err = 1'b1;
                        state_d  = (retry_q < RETRY_LIM) ? HALT : FAULT;
                    end else begin
                        take_commit = 1'b1;
                    end
                end
            end
            HALT:     state_d = ROLLBACK;
            ROLLBACK: state_d = WAIT_DONE;
            WAIT_DONE: begin
                // rollback_done takes priority over an expiring timeout
                if (rollback_done)
                    state_d = RUN;
                else if (tcnt_q == TO_LAST)
                    state_d = FAULT;
            end
            FAULT:    state_d = FAULT;
            default:  state_d = RUN;
        endcase
    end

    // State register and state-decoded outputs, registered from the next state
    // so each output lines up with the state it belongs to.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= RUN;
            halt_q     <= 1'b0;
            rollback_q <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            halt_q     <= (state_d != RUN);
            rollback_q <= (state_d == ROLLBACK);
            fault_q    <= (state_d == FAULT);
        end
    end

    // Checkpoint capture and commit strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ckpt_q         <= '0;
            commit_valid_q <= 1'b0;
        end else begin
            commit_valid_q <= take_commit;
            if (take_commit)
                ckpt_q <= data;
        end
    end

    // Retry count: cleared by a good commit, bumped once per rollback.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            retry_q <= '0;
        else if (take_commit)
            retry_q <= '0;
        else if (state_q == ROLLBACK)
            retry_q <= retry_q + RW'(1);
    end

    // Timeout counter: zero outside WAIT_DONE, so it starts at 0 on entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            tcnt_q <= '0;
        else if (state_q == WAIT_DONE)
            tcnt_q <= tcnt_q + TW'(1);
        else
            tcnt_q <= '0;
    end

    sat_counter #(
        .W (ERR_W)
    ) u_err (
        .clk   (clk),
        .reset (reset),
        .inc   (take_err),
        .count (error_count)
    );

    assign halt          = halt_q;
    assign rollback      = rollback_q;
    assign fault         = fault_q;
    assign commit_valid  = commit_valid_q;
    assign commit_data   = ckpt_q;
    assign rollback_data = ckpt_q;

endmodule

// File: tb/tb_recovery_ctrl.sv
// Directed bench for recovery_ctrl: vector table plus multi-cycle sequences.
module tb_recovery_ctrl;

    localparam int unsigned W   = 32;
    localparam int unsigned MR  = 3;
    localparam int unsigned TO  = 64;
    localparam int unsigned NV  = 11;

    logic          clk;
    logic          reset;
    logic          result_valid;
    logic          signal;
    logic [W-1:0]  data;
    logic          rollback_done;
    logic          halt;
    logic          rollback;
    logic [W-1:0]  rollback_data;
    logic          commit_valid;
    logic [W-1:0]  commit_data;
    logic          fault;
    logic [15:0]   error_count;

    int checks = 0;
    int errors = 0;
    int rb_cnt = 0;
    int base;

    typedef struct {
        logic        rv;
        logic        sig;
        logic [31:0] d;
        logic        done;
        logic        e_halt;
        logic        e_rb;
        logic        e_cv;
        logic [31:0] e_cd;
        logic        e_flt;
        logic [15:0] e_ec;
    } vec_t;

    vec_t vecs [NV];

    recovery_ctrl #(
        .WIDTH     (W),
        .MAX_RETRY (MR),
        .TIMEOUT   (TO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .result_valid  (result_valid),
        .signal        (signal),
        .data          (data),
        .rollback_done (rollback_done),
        .halt          (halt),
        .rollback      (rollback),
        .rollback_data (rollback_data),
        .commit_valid  (commit_valid),
        .commit_data   (commit_data),
        .fault         (fault),
        .error_count   (error_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rollback pulses seen mid-cycle.
    always @(negedge clk) begin
        if (rollback === 1'b1)
            rb_cnt <= rb_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rv, input logic sg, input logic [31:0] d, input logic dn);
        result_valid  = rv;
        signal        = sg;
        data          = d;
        rollback_done = dn;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drive(0, 0, 0, 0);
        cycle();
        cycle();
        reset = 1'b1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".halt"}, halt, 0);
        chk({tag, ".rollback"}, rollback, 0);
        chk({tag, ".commit_valid"}, commit_valid, 0);
        chk({tag, ".commit_data"}, commit_data, 0);
        chk({tag, ".rollback_data"}, rollback_data, 0);
        chk({tag, ".fault"}, fault, 0);
        chk({tag, ".error_count"}, error_count, 0);
    endtask

    // Mismatch, then rollback_done as soon as WAIT_DONE is reached; ends in RUN.
    task automatic mismatch_and_recover(input logic [31:0] d);
        drive(1, 1, d, 0);
        cycle();              // -> HALT
        drive(0, 0, 0, 0);
        cycle();              // -> ROLLBACK
        cycle();              // -> WAIT_DONE
        drive(0, 0, 0, 1);
        cycle();              // -> RUN
        drive(0, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0);
        #1 reset = 1'b0;
        #1;
        chk_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        //            rv sig data   done| halt rb cv cd     flt ec
        vecs[0]  = '{0, 0, 32'd0,  0,   0,   0, 0, 32'd0,  0, 16'd0};
        vecs[1]  = '{1, 0, 32'd10, 0,   0,   0, 1, 32'd10, 0, 16'd0};
        vecs[2]  = '{0, 0, 32'd0,  0,   0,   0, 0, 32'd10, 0, 16'd0};
        vecs[3]  = '{1, 1, 32'd11, 0,   1,   0, 0, 32'd10, 0, 16'd1};
        vecs[4]  = '{1, 0, 32'd99, 1,   1,   1, 0, 32'd10, 0, 16'd1};
        vecs[5]  = '{1, 1, 32'd77, 1,   1,   0, 0, 32'd10, 0, 16'd1};
        vecs[6]  = '{0, 0, 32'd0,  0,   1,   0, 0, 32'd10, 0, 16'd1};
        vecs[7]  = '{1, 0, 32'd55, 1,   0,   0, 0, 32'd10, 0, 16'd1};
        vecs[8]  = '{1, 0, 32'd20, 0,   0,   0, 1, 32'd20, 0, 16'd1};
        vecs[9]  = '{0, 0, 32'd0,  1,   0,   0, 0, 32'd20, 0, 16'd1};
        vecs[10] = '{1, 1, 32'd21, 0,   1,   0, 0, 32'd20, 0, 16'd2};

        for (int i = 0; i < int'(NV); i++) begin
            drive(vecs[i].rv, vecs[i].sig, vecs[i].d, vecs[i].done);
            cycle();
            chk($sformatf("v%0d.halt", i), halt, vecs[i].e_halt);
            chk($sformatf("v%0d.rollback", i), rollback, vecs[i].e_rb);
            chk($sformatf("v%0d.commit_valid", i), commit_valid, vecs[i].e_cv);
            chk($sformatf("v%0d.commit_data", i), commit_data, vecs[i].e_cd);
            chk($sformatf("v%0d.rollback_data", i), rollback_data, vecs[i].e_cd);
            chk($sformatf("v%0d.fault", i), fault, vecs[i].e_flt);
            chk($sformatf("v%0d.error_count", i), error_count, vecs[i].e_ec);
        end

        // Retry exhaustion: three rollbacks, fourth mismatch faults.
        do_reset();
        drive(1, 0, 32'd10, 0);
        cycle();
        drive(0, 0, 0, 0);
        base = rb_cnt;
        for (int k = 0; k < int'(MR); k++) begin
            mismatch_and_recover(32'd11);
            chk($sformatf("retry%0d.halt", k), halt, 0);
            chk($sformatf("retry%0d.fault", k), fault, 0);
        end
        drive(1, 1, 32'd12, 0);
        cycle();
        drive(0, 0, 0, 0);
        chk("exhaust.fault", fault, 1);
        chk("exhaust.halt", halt, 1);
        chk("exhaust.error_count", error_count, 4);
        chk("exhaust.rollbacks", rb_cnt - base, 3);
        for (int k = 0; k < 8; k++) begin
            drive(1'($urandom_range(1)), 1'($urandom_range(1)), $urandom, 1'($urandom_range(1)));
            cycle();
            chk($sformatf("fault_hold%0d.fault", k), fault, 1);
            chk($sformatf("fault_hold%0d.halt", k), halt, 1);
            chk($sformatf("fault_hold%0d.commit_valid", k), commit_valid, 0);
            chk($sformatf("fault_hold%0d.rollback", k), rollback, 0);
        end
        chk("fault_hold.error_count", error_count, 4);
        chk("fault_hold.commit_data", commit_data, 10);

        // Reset while in FAULT.
        drive(0, 0, 0, 0);
        #2 reset = 1'b0;
        #1;
        chk_all_zero("rst_fault");

        // Timeout with rollback_done never asserted.
        do_reset();
        drive(1, 1, 32'd5, 0);
        cycle();
        drive(0, 0, 0, 0);
        cycle();
        cycle();              // WAIT_DONE entry
        chk("to_entry.halt", halt, 1);
        chk("to_entry.fault", fault, 0);
        repeat (TO - 1) cycle();
        chk("to_before.fault", fault, 0);
        cycle();
        chk("to_expire.fault", fault, 1);
        chk("to_expire.halt", halt, 1);

        // rollback_done on the expiring cycle wins.
        do_reset();
        drive(1, 1, 32'd5, 0);
        cycle();
        drive(0, 0, 0, 0);
        cycle();
        cycle();
        repeat (TO - 1) cycle();
        drive(0, 0, 0, 1);
        cycle();
        drive(0, 0, 0, 0);
        chk("to_race.fault", fault, 0);
        chk("to_race.halt", halt, 0);
        cycle();
        chk("to_race_after.fault", fault, 0);

        // Reset while in WAIT_DONE, no clock edge needed.
        do_reset();
        drive(1, 0, 32'd10, 0);
        cycle();
        mismatch_and_recover(32'd3);
        drive(1, 1, 32'd3, 0);
        cycle();
        drive(0, 0, 0, 0);
        cycle();
        cycle();              // WAIT_DONE
        chk("wait.halt", halt, 1);
        #2 reset = 1'b0;
        #1;
        chk_all_zero("rst_wait");

        // Reset during ROLLBACK: pulse aborted, nothing leaks after release.
        do_reset();
        drive(1, 0, 32'd10, 0);
        cycle();
        drive(1, 1, 32'd4, 0);
        cycle();
        drive(0, 0, 0, 0);
        cycle();              // ROLLBACK
        chk("rb_state.rollback", rollback, 1);
        #2 reset = 1'b0;
        #1;
        chk("rst_rb.rollback", rollback, 0);
        chk("rst_rb.halt", halt, 0);
        base = rb_cnt;
        cycle();
        cycle();
        reset = 1'b1;
        repeat (5) cycle();
        chk("rst_rb.leak", rb_cnt - base, 0);
        chk("rst_rb.halt_after", halt, 0);

        // Error counter saturation.
        do_reset();
        force dut.u_err.count_q = 16'hFFFE;
        cycle();
        release dut.u_err.count_q;
        cycle();
        chk("sat.preload", error_count, 16'hFFFE);
        mismatch_and_recover(32'd1);
        chk("sat.first", error_count, 16'hFFFF);
        drive(1, 1, 32'd2, 0);
        cycle();
        drive(0, 0, 0, 0);
        chk("sat.second", error_count, 16'hFFFF);
        chk("sat.halt", halt, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
